// File: rtl/ula_pkg.sv
// Shared types and constants for the byte-serial ALU wrapper.
package ula_pkg;

  localparam int BYTE_W = 8;

  // Common 74181 function selects
  localparam logic [3:0] S_ADD        = 4'b1001;
  localparam logic [3:0] S_A_PLUS_CIN = 4'b0000;
  localparam logic [3:0] S_XOR        = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ula_8bits.sv
// 8-bit 74181-style ALU, active-high data and active-high carry.
// Arithmetic results are P + Q + c_in, so byte slices chain cleanly
// through c_out -> c_in. Logic mode reports c_out = 0.
module ula_8bits
  import ula_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic [3:0]        s,
  input  logic              m,
  input  logic              c_in,
  output logic [BYTE_W-1:0] f,
  output logic              c_out
);

  logic [BYTE_W-1:0] p, q, lf;
  logic [BYTE_W:0]   sum;

  // Operand selection for the adder and the logic-mode function table
  always_comb begin
    p = a;
    q = '0;
    case (s)
      4'b0000: begin p = a;        q = '0;      end
      4'b0001: begin p = a | b;    q = '0;      end
      4'b0010: begin p = a | ~b;   q = '0;      end
      4'b0011: begin p = '0;       q = '1;      end
      4'b0100: begin p = a;        q = a & ~b;  end
      4'b0101: begin p = a | b;    q = a & ~b;  end
      4'b0110: begin p = a;        q = ~b;      end
      4'b0111: begin p = a & ~b;   q = '1;      end
      4'b1000: begin p = a;        q = a & b;   end
      4'b1001: begin p = a;        q = b;       end
      4'b1010: begin p = a | ~b;   q = a & b;   end
      4'b1011: begin p = a & b;    q = '1;      end
      4'b1100: begin p = a;        q = a;       end
      4'b1101: begin p = a | b;    q = a;       end
      4'b1110: begin p = a | ~b;   q = a;       end
      default: begin p = a;        q = '1;      end
    endcase
    case (s)
      4'b0000: lf = ~a;
      4'b0001: lf = ~(a | b);
      4'b0010: lf = ~a & b;
      4'b0011: lf = '0;
      4'b0100: lf = ~(a & b);
      4'b0101: lf = ~b;
      4'b0110: lf = a ^ b;
      4'b0111: lf = a & ~b;
      4'b1000: lf = ~a | b;
      4'b1001: lf = ~(a ^ b);
      4'b1010: lf = b;
      4'b1011: lf = a & b;
      4'b1100: lf = '1;
      4'b1101: lf = a | ~b;
      4'b1110: lf = a | b;
      default: lf = a;
    endcase
    sum   = {1'b0, p} + {1'b0, q} + {{BYTE_W{1'b0}}, c_in};
    f     = m ? lf : sum[BYTE_W-1:0];
    c_out = m ? 1'b0 : sum[BYTE_W];
  end

endmodule

// File: rtl/ula_multibyte_seq.sv
// Wide ALU operation executed LSB-first, one byte per clock, through a
// single ula_8bits. Carry is chained byte to byte via carry_q.
module ula_multibyte_seq
  import ula_pkg::*;
#(
  parameter int NUM_BYTES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BYTE_W*NUM_BYTES-1:0] a,
  input  logic [BYTE_W*NUM_BYTES-1:0] b,
  input  logic [3:0]                  s,
  input  logic                        m,
  input  logic                        c_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BYTE_W*NUM_BYTES-1:0] f,
  output logic                        c_out,
  output logic                        zero
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES - 1);

  state_e                              state;
  logic [IDX_W-1:0]                    idx;
  logic [NUM_BYTES-1:0][BYTE_W-1:0]    a_q, b_q, f_q, f_next;
  logic [3:0]                          s_q;
  logic                                m_q, cin_q, carry_q, c_out_q, zero_q;
  logic [BYTE_W-1:0]                   a_byte, b_byte, alu_f;
  logic                                alu_cin, alu_cout;

  // Select the active byte slice and merge the ALU byte into the result.
  // A compare-per-byte mux avoids indexing past the array for odd sizes.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    f_next = f_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_byte    = a_q[i];
        b_byte    = b_q[i];
        f_next[i] = alu_f;
      end
    end
    alu_cin = (idx == '0) ? cin_q : carry_q;
  end

  ula_8bits u_alu (
    .a     (a_byte),
    .b     (b_byte),
    .s     (s_q),
    .m     (m_q),
    .c_in  (alu_cin),
    .f     (alu_f),
    .c_out (alu_cout)
  );

  // Command capture, byte sequencing and result hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      f_q     <= '0;
      c_out_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          s_q   <= s;
          m_q   <= m;
          cin_q <= c_in;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          f_q     <= f_next;
          carry_q <= alu_cout;
          if (idx == LAST) begin
            c_out_q <= alu_cout;
            zero_q  <= (f_next == '0);
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign f         = f_q;
  assign c_out     = c_out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_ula_multibyte_seq.sv
// Bench for ula_multibyte_seq: a 2-byte and a 1-byte instance, directed
// cases plus randomized commands checked against a wide-arithmetic model.
module tb_ula_multibyte_seq;
  import ula_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-byte instance
  logic        in_valid, in_ready, out_valid, out_ready, m, c_in, c_out, zero;
  logic [15:0] a, b, f;
  logic [3:0]  s;
  // 1-byte instance
  logic        in_valid1, in_ready1, out_valid1, out_ready1, m1, c_in1, c_out1, zero1;
  logic [7:0]  a1, b1, f1;
  logic [3:0]  s1;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] last_f;
  logic        last_c, last_z;

  ula_multibyte_seq #(.NUM_BYTES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .c_out(c_out), .zero(zero)
  );

  ula_multibyte_seq #(.NUM_BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .s(s1), .m(m1), .c_in(c_in1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .f(f1), .c_out(c_out1), .zero(zero1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-width 74181 semantics. Returns {carry, result}.
  function automatic logic [32:0] ref_alu(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] sel, input logic mode, input logic ci);
    logic [31:0] mask, lhs, rhs, res;
    logic [32:0] sum;
    mask = (32'd1 << w) - 32'd1;
    x = x & mask;
    y = y & mask;
    if (mode) begin
      case (sel)
        4'h0: res = ~x;        4'h1: res = ~(x | y);
        4'h2: res = ~x & y;    4'h3: res = 32'd0;
        4'h4: res = ~(x & y);  4'h5: res = ~y;
        4'h6: res = x ^ y;     4'h7: res = x & ~y;
        4'h8: res = ~x | y;    4'h9: res = ~(x ^ y);
        4'hA: res = y;         4'hB: res = x & y;
        4'hC: res = 32'hFFFF_FFFF; 4'hD: res = x | ~y;
        4'hE: res = x | y;     default: res = x;
      endcase
      return {1'b0, res & mask};
    end
    // Arithmetic: lhs + rhs + carry, where "minus 1" adds all-ones
    case (sel)
      4'h0: begin lhs = x;          rhs = 32'd0;   end
      4'h1: begin lhs = x | y;      rhs = 32'd0;   end
      4'h2: begin lhs = x | ~y;     rhs = 32'd0;   end
      4'h3: begin lhs = 32'd0;      rhs = mask;    end
      4'h4: begin lhs = x;          rhs = x & ~y;  end
      4'h5: begin lhs = x | y;      rhs = x & ~y;  end
      4'h6: begin lhs = x;          rhs = ~y;      end
      4'h7: begin lhs = x & ~y;     rhs = mask;    end
      4'h8: begin lhs = x;          rhs = x & y;   end
      4'h9: begin lhs = x;          rhs = y;       end
      4'hA: begin lhs = x | ~y;     rhs = x & y;   end
      4'hB: begin lhs = x & y;      rhs = mask;    end
      4'hC: begin lhs = x;          rhs = x;       end
      4'hD: begin lhs = x | y;      rhs = x;       end
      4'hE: begin lhs = x | ~y;     rhs = x;       end
      default: begin lhs = x;       rhs = mask;    end
    endcase
    sum = {1'b0, lhs & mask} + {1'b0, rhs & mask} + {32'd0, ci};
    return {sum[w], sum[31:0] & mask};
  endfunction

  // One command on the 2-byte instance; bp = cycles of output stall,
  // pend = present a follow-up command (0101+0202 ADD) while stalled.
  task automatic op2(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] ts,
                     input logic tm, input logic tc, input int bp, input bit pend);
    logic [32:0] r;
    int k;
    r = ref_alu(16, {16'd0, ta}, {16'd0, tb}, ts, tm, tc);
    a = ta; b = tb; s = ts; m = tm; c_in = tc; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    check("accept_wait", 64'(k < 50), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom); c_in = 1'($urandom);
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
    check("latency2", k, 2);
    check("f2", f, r[15:0]);
    check("c_out2", c_out, r[32]);
    check("zero2", zero, 64'(r[15:0] == 16'd0));
    check("busy_in_ready", in_ready, 0);
    if (pend) begin
      a = 16'h0101; b = 16'h0202; s = S_ADD; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("hold_result", {f, c_out, zero}, {r[15:0], r[32], r[15:0] == 16'd0});
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    last_f = f; last_c = c_out; last_z = zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  // One command on the 1-byte instance
  task automatic op1(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] ts,
                     input logic tm, input logic tc);
    logic [32:0] r;
    int k;
    r = ref_alu(8, {24'd0, ta}, {24'd0, tb}, ts, tm, tc);
    a1 = ta; b1 = tb; s1 = ts; m1 = tm; c_in1 = tc; in_valid1 = 1'b1;
    k = 0;
    while (!in_ready1 && k < 50) begin @(posedge clk); #1; k++; end
    check("accept_wait1", 64'(k < 50), 64'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom);
    k = 0;
    while (!out_valid1 && k < 50) begin @(posedge clk); #1; k++; end
    check("latency1", k, 1);
    check("f1", f1, r[7:0]);
    check("c_out1", c_out1, r[32]);
    check("zero1", zero1, 64'(r[7:0] == 8'd0));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("release_valid1", out_valid1, 0);
  endtask

  // Safety net against a hung handshake
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; out_ready = 0; a = 0; b = 0; s = 0; m = 0; c_in = 0;
    in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; s1 = 0; m1 = 0; c_in1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_f", f, 0);
    check("rst_c_out", c_out, 0);
    check("rst_zero", zero, 0);
    check("rst_in_ready1", in_ready1, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry crosses the byte boundary
    op2(16'h00FF, 16'h0001, S_ADD, 1'b0, 1'b0, 0, 1'b0);
    check("t1_f", last_f, 16'h0100);
    check("t1_c", last_c, 0);
    check("t1_z", last_z, 0);

    // Carry ripples through every byte and out the top
    op2(16'hFFFF, 16'h0000, S_A_PLUS_CIN, 1'b0, 1'b1, 0, 1'b0);
    check("t2_f", last_f, 16'h0000);
    check("t2_c", last_c, 1);
    check("t2_z", last_z, 1);

    op2(16'h5A5A, 16'h3333, S_XOR, 1'b1, 1'b0, 0, 1'b0);
    check("t3_f", last_f, 16'h6969);

    // Output stall with a command waiting; it goes in right after release
    op2(16'h1357, 16'h2468, S_ADD, 1'b0, 1'b1, 5, 1'b1);
    check("t4_f", last_f, 16'h37C0);
    op2(16'h0101, 16'h0202, S_ADD, 1'b0, 1'b0, 0, 1'b0);
    check("t4_pending_f", last_f, 16'h0303);

    // Reset in the middle of RUN aborts the command
    a = 16'hABCD; b = 16'h1111; s = S_ADD; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_f", f, 0);
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_c_out", c_out, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_no_result", out_valid, 0);
    op2(16'h1234, 16'h1111, S_ADD, 1'b0, 1'b0, 0, 1'b0);
    check("t5_f", last_f, 16'h2345);

    // Single-byte build
    op1(8'hC3, 8'h5E, S_A_PLUS_CIN, 1'b0, 1'b1);
    check("t6_f", f1, 8'hC4);
    check("t6_c", c_out1, 0);

    // Randomized commands
    for (int i = 0; i < 40; i++)
      op2(16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)), 1'b0);
    for (int i = 0; i < 20; i++)
      op1(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
